adder_response_checker: RTL and testbench
=========================================

// Module: adder_response_checker
// PURPOSE
// - Self-checking response monitor: the receiving end of adder stimulus.
//   Each valid sample carries the operands driven into an adder plus the
//   adder's outputs. The block compares them against a golden sum.
// - Counts passes and failures, records which input combinations were seen,
//   captures the first mismatch, and flags done when coverage is complete.
// - Sits beside any full-adder or ripple-adder DUT in simulation or on-chip BIST.
// PARAMETERS
// - WIDTH         1   operand width in bits; legal range 1..3
// - CNT_W         16  width of the pass/fail counters; counters saturate
// - STOP_ON_FAIL  0   1 = go to DONE on the first mismatch
// PORTS
// - clk             in   1            rising-edge clock; the only clock
// - rst_n           in   1            synchronous, active-low reset
// - start           in   1            1-cycle pulse; clears all results and enters RUN
// - in_valid        in   1            sample valid this cycle
// - a               in   WIDTH        operand A driven to the DUT
// - b               in   WIDTH        operand B driven to the DUT
// - cin             in   1            carry-in driven to the DUT
// - sum             in   WIDTH        DUT sum output
// - cout            in   1            DUT carry output
// - pass_cnt        out  CNT_W        count of matching samples
// - fail_cnt        out  CNT_W        count of mismatching samples
// - cov_map         out  2^(2W+1)     bit {a,b,cin} set once that vector has been seen
// - all_covered     out  1            cov_map is all ones
// - busy            out  1            state == RUN
// - done            out  1            state == DONE
// - err             out  1            at least one mismatch since the last start
// - first_fail_vec  out  2W+1         {a,b,cin} of the first mismatch
// - first_fail_got  out  W+1          {cout,sum} of the first mismatch
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - state goes to IDLE.
//   - Every output is 0, including all counters, cov_map and the capture registers.
// - States and transitions:
//   - IDLE: start -> RUN.
//   - RUN: start -> RUN and clears all results.
//   - RUN: the accepted sample that completes coverage -> DONE.
//   - RUN: a mismatch with STOP_ON_FAIL=1 -> DONE.
//   - DONE: start -> RUN and clears all results.
// - Samples are accepted only in RUN, with in_valid=1 and start=0.
//   - In IDLE and DONE, samples are ignored and no register changes.
// - Golden check: exp = a + b + cin, computed WIDTH+1 bits wide and zero-extended.
//   - Match when {cout,sum} == exp.
// - Accepted sample updates, all registered and visible 1 cycle after acceptance:
//   - pass_cnt += match, or fail_cnt += !match.
//   - Both counters saturate at all-ones and never wrap.
//   - cov_map[{a,b,cin}] is set, whether the sample matches or not.
//   - On the first mismatch, err <= 1 and first_fail_vec/got are captured.
//   - Later mismatches never overwrite the capture.
// - The sample that causes the move to DONE is fully counted.
//   - done rises on the same edge as that sample's counter update.
// - start together with in_valid: start wins and the sample is dropped.
// - rst_n=0 mid-RUN: immediate return to IDLE with all results cleared.
//   - rst_n takes priority over start.
// - Outputs hold their values in DONE and IDLE until the next start or reset.
// TESTING
// - T1 reset: hold rst_n=0 for 2 cycles -> every output 0, busy=0, done=0.
// - T2 full pass (W=1): start, then 8 correct vectors 000..111 on consecutive cycles.
//   - pass_cnt=8, fail_cnt=0, cov_map=8'hFF, err=0.
//   - done=1 on the edge after the 8th sample.
// - T3 fault, STOP_ON_FAIL=0: vector a=1,b=1,cin=0 returns sum=1,cout=0.
//   - fail_cnt=1, err=1, first_fail_vec=3'b110, first_fail_got=2'b01.
//   - A second bad vector 111 -> fail_cnt=2, capture unchanged.
//   - Run continues to done after all 8 vectors are seen.
// - T4 STOP_ON_FAIL=1: the first sample is a mismatch -> done=1 next cycle.
//   - 3 further valid samples leave pass/fail/cov unchanged.
// - T5 saturation (CNT_W=3): 10 correct samples of vector 000.
//   - pass_cnt=7, cov_map=8'h01, busy=1.
// - T6 restart and reset: start mid-RUN after 3 samples -> all results 0, busy=1.
//   - start with in_valid in the same cycle -> that sample is not counted.
//   - rst_n=0 mid-RUN -> IDLE, all outputs 0.

Source files
------------

// File: rtl/adder_response_checker.sv
// Response monitor for full/ripple adder stimulus: checks {cout,sum} against a golden
// a+b+cin, counts pass/fail, tracks vector coverage and captures the first mismatch.
module adder_response_checker #(
   parameter int WIDTH        = 1,
   parameter int CNT_W        = 16,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            a,
   input  logic [WIDTH-1:0]            b,
   input  logic                        cin,
   input  logic [WIDTH-1:0]            sum,
   input  logic                        cout,
   output logic [CNT_W-1:0]            pass_cnt,
   output logic [CNT_W-1:0]            fail_cnt,
   output logic [2**(2*WIDTH+1)-1:0]   cov_map,
   output logic                        all_covered,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [2*WIDTH:0]            first_fail_vec,
   output logic [WIDTH:0]              first_fail_got
);
   localparam int VEC_W = 2*WIDTH+1;
   localparam int COV_N = 2**VEC_W;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic             accept;
   logic             match;
   logic [VEC_W-1:0] vec;
   logic [WIDTH:0]   got;
   logic [WIDTH:0]   exp_sum;
   logic [COV_N-1:0] cov_next;

   assign vec     = {a, b, cin};
   assign got     = {cout, sum};
   assign exp_sum = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
   assign match   = (got == exp_sum);
   // start takes precedence over a coincident sample
   assign accept  = (state == RUN) && in_valid && !start;

   always_comb begin
      cov_next      = cov_map;
      cov_next[vec] = 1'b1;
   end

   assign all_covered = &cov_map;
   assign busy        = (state == RUN);
   assign done        = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         state          <= rst_n ? RUN : IDLE;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         cov_map        <= '0;
         err            <= 1'b0;
         first_fail_vec <= '0;
         first_fail_got <= '0;
      end else if (accept) begin
         cov_map <= cov_next;
         if (match) begin
            if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + CNT_W'(1);
         end else begin
            if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + CNT_W'(1);
            if (!err) begin
               err            <= 1'b1;
               first_fail_vec <= vec;
               first_fail_got <= got;
            end
         end
         if ((&cov_next) || (!match && STOP_ON_FAIL)) state <= DONE;
      end
   end
endmodule

// File: tb/tb_adder_response_checker.sv
// Scoreboard bench for adder_response_checker: three instances (default, stop-on-fail,
// 3-bit counters) share stimulus; expectations are queued and checked on the falling edge.
module tb_adder_response_checker;
   logic clk = 1'b0;
   logic rst_n, start, in_valid, a, b, cin, sum, cout;
   always #5 clk = ~clk;

   logic [15:0] p0, f0, p1, f1;
   logic [2:0]  p2, f2;
   logic [7:0]  c0, c1, c2;
   logic        al0, al1, al2, bz0, bz1, bz2, dn0, dn1, dn2, er0, er1, er2;
   logic [2:0]  fv0, fv1, fv2;
   logic [1:0]  fg0, fg1, fg2;

   adder_response_checker #(.WIDTH(1), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .pass_cnt(p0), .fail_cnt(f0), .cov_map(c0), .all_covered(al0),
      .busy(bz0), .done(dn0), .err(er0), .first_fail_vec(fv0), .first_fail_got(fg0));
   adder_response_checker #(.WIDTH(1), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .pass_cnt(p1), .fail_cnt(f1), .cov_map(c1), .all_covered(al1),
      .busy(bz1), .done(dn1), .err(er1), .first_fail_vec(fv1), .first_fail_got(fg1));
   adder_response_checker #(.WIDTH(1), .CNT_W(3), .STOP_ON_FAIL(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .pass_cnt(p2), .fail_cnt(f2), .cov_map(c2), .all_covered(al2),
      .busy(bz2), .done(dn2), .err(er2), .first_fail_vec(fv2), .first_fail_got(fg2));

   // {pass16, fail16, cov8, all, busy, done, err, ffv3, ffg2}
   typedef struct {
      int          id;
      string       name;
      logic [48:0] v;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // correct {cout,sum} for vectors {a,b,cin} = 0..7
   logic [1:0] good [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   task automatic push(input int id, input string nm, input int p, input int f,
                       input logic [7:0] cov, input bit e, input bit bz, input bit dn,
                       input logic [2:0] fv, input logic [1:0] fg);
      exp_t x;
      x.id = id; x.name = nm;
      x.v = {16'(p), 16'(f), cov, (cov == 8'hFF), bz, dn, e, fv, fg};
      q.push_back(x);
   endtask

   task automatic drive(input bit st, input bit vl, input logic [2:0] vec, input logic [1:0] gt);
      start = st; in_valid = vl; {a, b, cin} = vec; {cout, sum} = gt;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t x;
         logic [48:0] act;
         x = q.pop_front();
         case (x.id)
            0: act = {p0, f0, c0, al0, bz0, dn0, er0, fv0, fg0};
            1: act = {p1, f1, c1, al1, bz1, dn1, er1, fv1, fg1};
            default: act = {13'd0, p2, 13'd0, f2, c2, al2, bz2, dn2, er2, fv2, fg2};
         endcase
         checks++;
         if (act !== x.v) begin
            errors++;
            $display("FAIL %s u%0d: got pass=%0d fail=%0d cov=%h all/busy/done/err=%b ffv=%b ffg=%b, want pass=%0d fail=%0d cov=%h all/busy/done/err=%b ffv=%b ffg=%b",
                     x.name, x.id, act[48:33], act[32:17], act[16:9], act[8:5], act[4:2], act[1:0],
                     x.v[48:33], x.v[32:17], x.v[16:9], x.v[8:5], x.v[4:2], x.v[1:0]);
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; {a, b, cin, sum, cout} = '0;
      // T1 reset
      drive(0, 0, 3'd0, 2'd0);
      drive(0, 0, 3'd0, 2'd0);
      for (int i = 0; i < 3; i++) push(i, "reset", 0, 0, 8'h00, 0, 0, 0, 3'b0, 2'b0);
      rst_n = 1'b1;
      drive(0, 1, 3'd3, 2'b10);
      push(0, "idle_ignore", 0, 0, 8'h00, 0, 0, 0, 3'b0, 2'b0);

      // T2 full pass
      drive(1, 0, 3'd0, 2'd0);
      push(0, "t2_start", 0, 0, 8'h00, 0, 1, 0, 3'b0, 2'b0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 3'(i), good[i]);
         if (i == 6) push(0, "t2_seven", 7, 0, 8'h7F, 0, 1, 0, 3'b0, 2'b0);
      end
      push(0, "t2_done", 8, 0, 8'hFF, 0, 0, 1, 3'b0, 2'b0);
      drive(0, 1, 3'd1, 2'b11);
      push(0, "t2_done_hold", 8, 0, 8'hFF, 0, 0, 1, 3'b0, 2'b0);

      // T3 faults without stop
      drive(1, 0, 3'd0, 2'd0);
      push(0, "t3_restart", 0, 0, 8'h00, 0, 1, 0, 3'b0, 2'b0);
      for (int i = 0; i < 6; i++) drive(0, 1, 3'(i), good[i]);
      drive(0, 1, 3'b110, 2'b01);
      push(0, "t3_first_fail", 6, 1, 8'h7F, 1, 1, 0, 3'b110, 2'b01);
      drive(0, 1, 3'b111, 2'b01);
      push(0, "t3_second_fail", 6, 2, 8'hFF, 1, 0, 1, 3'b110, 2'b01);

      // T4 stop on fail (u1)
      drive(1, 0, 3'd0, 2'd0);
      drive(0, 1, 3'b110, 2'b01);
      push(1, "t4_stop", 0, 1, 8'h40, 1, 0, 1, 3'b110, 2'b01);
      drive(0, 1, 3'd0, good[0]);
      drive(0, 1, 3'd1, good[1]);
      drive(0, 1, 3'd2, good[2]);
      push(1, "t4_ignored", 0, 1, 8'h40, 1, 0, 1, 3'b110, 2'b01);

      // T5 saturation (u2)
      drive(1, 0, 3'd0, 2'd0);
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 3'd0, 2'b00);
         if (i == 6) push(2, "t5_at_max", 7, 0, 8'h01, 0, 1, 0, 3'b0, 2'b0);
         if (i == 7) push(2, "t5_no_wrap", 7, 0, 8'h01, 0, 1, 0, 3'b0, 2'b0);
      end
      push(2, "t5_sat", 7, 0, 8'h01, 0, 1, 0, 3'b0, 2'b0);

      // T6 restart and reset (u0)
      drive(1, 0, 3'd0, 2'd0);
      for (int i = 0; i < 3; i++) drive(0, 1, 3'(i), good[i]);
      push(0, "t6_three", 3, 0, 8'h07, 0, 1, 0, 3'b0, 2'b0);
      drive(1, 0, 3'd0, 2'd0);
      push(0, "t6_restart", 0, 0, 8'h00, 0, 1, 0, 3'b0, 2'b0);
      drive(1, 1, 3'd3, good[3]);
      push(0, "t6_start_wins", 0, 0, 8'h00, 0, 1, 0, 3'b0, 2'b0);
      drive(0, 1, 3'd3, good[3]);
      push(0, "t6_after", 1, 0, 8'h08, 0, 1, 0, 3'b0, 2'b0);
      drive(0, 1, 3'd5, 2'b00);
      push(0, "t6_fail_mid", 1, 1, 8'h28, 1, 1, 0, 3'b101, 2'b00);
      rst_n = 1'b0;
      drive(1, 1, 3'd4, good[4]);
      push(0, "t6_reset_mid", 0, 0, 8'h00, 0, 0, 0, 3'b0, 2'b0);
      rst_n = 1'b1;
      drive(0, 1, 3'd4, good[4]);
      push(0, "t6_idle_after_rst", 0, 0, 8'h00, 0, 0, 0, 3'b0, 2'b0);

      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
